// File: rtl/pb_evt_pkg.sv
// pb_evt_pkg: shared types and defaults for the push-button event classifier.
//  - pb_evt_state_t : classifier FSM states
//  - PB_*_DEF       : default cycle counts for the long-press, double-click
//                     window and auto-repeat period
//  - max3           : constant helper used to size the shared counter
package pb_evt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HELD  = 3'd1,
        WAIT2 = 3'd2,
        HELD2 = 3'd3,
        LONG  = 3'd4
    } pb_evt_state_t;

    localparam int PB_LONG_CYC_DEF   = 100000;
    localparam int PB_DBL_CYC_DEF    = 40000;
    localparam int PB_REPEAT_CYC_DEF = 20000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

endpackage

// File: rtl/pb_evt_timer.sv
// pb_evt_timer: clear/enable saturating up-counter with terminal-count compare.
//  Parameter MAX sets the saturation value and the counter width.
//  Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear (wins over en)
//   en         : count enable; counter holds at MAX
//   term       : terminal value compared against the current count
//   cnt        : current count
//   tc         : high while cnt == term
module pb_evt_timer #(
    parameter int  MAX = 1,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic [W-1:0] cnt,
    output logic         tc
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] cnt_r;

    // Counter register: clear has priority, increment stops at MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {W{1'b0}};
        end else if (clr) begin
            cnt_r <= {W{1'b0}};
        end else if (en && (cnt_r != MAX_V)) begin
            cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;
    assign tc  = (cnt_r == term);

endmodule

// File: rtl/pb_event_classifier.sv
// pb_event_classifier: turns the synchronized button level and release pulse
// into short-press, long-press and double-click pulses for the UI logic.
//  Optional feature macro: PB_EVT_AUTOREPEAT_EN (auto-repeat ticks while a
//  long press is held; without it repeat_tick is tied low).
//  Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   pressed      : synchronized button level, 1 = held
//   released     : one-cycle pulse on button release
//   short_press  : one-cycle pulse, single short click
//   long_press   : one-cycle pulse, hold reached LONG_CYC
//   double_click : one-cycle pulse, second click released
//   repeat_tick  : one-cycle auto-repeat pulse
//   busy         : level, FSM not in IDLE
//  All event outputs are registered one cycle after their trigger cycle.
module pb_event_classifier
    import pb_evt_pkg::*;
#(
    parameter int LONG_CYC   = PB_LONG_CYC_DEF,
    parameter int DBL_CYC    = PB_DBL_CYC_DEF,
    parameter int REPEAT_CYC = PB_REPEAT_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pressed,
    input  logic released,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic repeat_tick,
    output logic busy
);

    localparam int CNT_MAX = max3(LONG_CYC, DBL_CYC, REPEAT_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_TERM  = CNT_W'(DBL_CYC - 1);
`ifdef PB_EVT_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RPT_TERM  = CNT_W'(REPEAT_CYC - 1);
`endif

    pb_evt_state_t state_r;
    pb_evt_state_t next_state_s;

    logic             press_s;
    logic             clr_s;
    logic             en_s;
    logic             wrap_s;
    logic             tc_s;
    logic [CNT_W-1:0] term_s;
    logic [CNT_W-1:0] cnt_unused_s;  // the FSM only needs the terminal-count flag
    logic             short_s;
    logic             long_s;
    logic             dbl_s;
    logic             short_r;
    logic             long_r;
    logic             dbl_r;
    logic             busy_r;

    // A release pulse overrides a coincident press level.
    assign press_s = pressed & ~released;

    pb_evt_timer #(
        .MAX (CNT_MAX)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_s),
        .en    (en_s),
        .term  (term_s),
        .cnt   (cnt_unused_s),
        .tc    (tc_s)
    );

`ifdef PB_EVT_AUTOREPEAT_EN
    logic rpt_s;
    logic rpt_r;
`endif

    // Next-state, counter control and event triggers.
    always_comb begin
        next_state_s = state_r;
        en_s         = 1'b0;
        wrap_s       = 1'b0;
        term_s       = {CNT_W{1'b0}};
        short_s      = 1'b0;
        long_s       = 1'b0;
        dbl_s        = 1'b0;
`ifdef PB_EVT_AUTOREPEAT_EN
        rpt_s        = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (press_s) begin
                    next_state_s = HELD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            HELD: begin
                term_s = LONG_TERM;
                if (released) begin
                    next_state_s = WAIT2;
                end else if (tc_s) begin
                    long_s       = 1'b1;
                    next_state_s = LONG;
                end else begin
                    en_s = 1'b1;
                end
            end
            WAIT2: begin
                // A press on the expiry cycle still counts as the second click.
                term_s = DBL_TERM;
                if (press_s) begin
                    next_state_s = HELD2;
                end else if (tc_s) begin
                    short_s      = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    en_s = 1'b1;
                end
            end
            HELD2: begin
                if (released) begin
                    dbl_s        = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = HELD2;
                end
            end
            LONG: begin
                if (released) begin
                    next_state_s = IDLE;
                end else begin
`ifdef PB_EVT_AUTOREPEAT_EN
                    term_s = RPT_TERM;
                    if (tc_s) begin
                        rpt_s  = 1'b1;
                        wrap_s = 1'b1;
                    end else begin
                        en_s = 1'b1;
                    end
`else
                    next_state_s = LONG;
`endif
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        clr_s = (next_state_s != state_r) || wrap_s;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Registered event pulses and busy level (busy tracks the next state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            short_r <= 1'b0;
            long_r  <= 1'b0;
            dbl_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            short_r <= short_s;
            long_r  <= long_s;
            dbl_r   <= dbl_s;
            busy_r  <= (next_state_s != IDLE);
        end
    end

`ifdef PB_EVT_AUTOREPEAT_EN
    // Registered auto-repeat tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rpt_r <= 1'b0;
        end else begin
            rpt_r <= rpt_s;
        end
    end
    assign repeat_tick = rpt_r;
`else
    assign repeat_tick = 1'b0;
`endif

    assign short_press  = short_r;
    assign long_press   = long_r;
    assign double_click = dbl_r;
    assign busy         = busy_r;

endmodule
